// File: rtl/ntt_bank_mapper_pkg.sv
// rtl/ntt_bank_mapper_pkg.sv - shared NTT constants and bank index type
package ntt_bank_mapper_pkg;

    localparam int RADIX     = 16;
    localparam int RADIX_LOG = 4;

    typedef logic [RADIX_LOG-1:0] bank_idx_t;

endpackage

// File: rtl/ntt_bank_mapper_bank_num.sv
// rtl/ntt_bank_mapper_bank_num.sv - combinational digit-sum mod 16 of a LOGN-bit index
//
// Ports:
//   idx  LOGN-bit index, split into 4-bit digits
//   bn   wrapping 4-bit sum of all digits (bank number)
module ntt_bank_num
    import ntt_bank_mapper_pkg::*;
#(
    parameter int LOGN = 12
) (
    input  logic [LOGN-1:0] idx,
    output bank_idx_t       bn
);

    // The 4-bit accumulator wraps naturally, which gives the mod-16 for free.
    always_comb begin
        bn = '0;
        for (int k = 0; k < LOGN / RADIX_LOG; k++) begin
            bn = bn + idx[k*RADIX_LOG +: RADIX_LOG];
        end
    end

endmodule

// File: rtl/ntt_bank_mapper.sv
// rtl/ntt_bank_mapper.sv - pipelined conflict-free bank mapper for radix-16 NTT
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_en          order_in / in_l / in_done valid this cycle
//   order_in       16 indices, lane m at [m*D_WIDTH +: D_WIDTH]
//   in_l, in_done  stage number and end-of-transform flag for the group
//   map_valid      mapped outputs valid (2 cycles after the sampling edge)
//   bank_addr      per-bank internal address, bank b at [b*MA_W +: MA_W]
//   lane_sel       per-bank source lane, bank b at [b*4 +: 4]
//   map_l,map_done in_l / in_done aligned with the mapped outputs
//   group_cnt      groups emitted in the current transform
//   conflict_err   sticky: two lanes of a group hit the same bank
//   range_err      sticky: an index had bits set at LOGN or above
module ntt_bank_mapper
    import ntt_bank_mapper_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int LOGN    = 12,
    parameter int MA_W    = LOGN - 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_en,
    input  logic [RADIX*D_WIDTH-1:0]  order_in,
    input  logic [D_WIDTH-1:0]        in_l,
    input  logic                      in_done,
    output logic                      map_valid,
    output logic [RADIX*MA_W-1:0]     bank_addr,
    output logic [RADIX*RADIX_LOG-1:0] lane_sel,
    output logic [D_WIDTH-1:0]        map_l,
    output logic                      map_done,
    output logic [MA_W-1:0]           group_cnt,
    output logic                      conflict_err,
    output logic                      range_err
);

    localparam int LANES = RADIX;

    // ---------------- input capture ----------------
    // Only the low LOGN bits of each index are kept; the upper bits collapse
    // into a single out-of-range flag for the group.
    logic [LANES-1:0]   lane_oor;
    logic               s0_valid;
    logic               s0_done;
    logic               s0_range;
    logic [D_WIDTH-1:0] s0_l;
    logic [LOGN-1:0]    s0_idx [LANES];

    for (genvar m = 0; m < LANES; m++) begin : g_oor
        assign lane_oor[m] = (order_in[m*D_WIDTH +: D_WIDTH] >> LOGN) != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_done  <= 1'b0;
            s0_range <= 1'b0;
            s0_l     <= '0;
            for (int k = 0; k < LANES; k++) s0_idx[k] <= '0;
        end else begin
            s0_valid <= in_en;
            if (in_en) begin
                s0_done  <= in_done;
                s0_range <= |lane_oor;
                s0_l     <= in_l;
                for (int k = 0; k < LANES; k++) begin
                    s0_idx[k] <= order_in[k*D_WIDTH +: LOGN];
                end
            end
        end
    end

    // ---------------- stage 1: bank number / internal address ----------------
    bank_idx_t        bn_c  [LANES];
    logic             s1_valid;
    logic             s1_done;
    logic             s1_range;
    logic [D_WIDTH-1:0] s1_l;
    bank_idx_t        s1_bn [LANES];
    logic [MA_W-1:0]  s1_ma [LANES];

    for (genvar m = 0; m < LANES; m++) begin : g_bn
        ntt_bank_num #(.LOGN(LOGN)) u_bank_num (
            .idx (s0_idx[m]),
            .bn  (bn_c[m])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_done  <= 1'b0;
            s1_range <= 1'b0;
            s1_l     <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_bn[k] <= '0;
                s1_ma[k] <= '0;
            end
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_done  <= s0_done;
                s1_range <= s0_range;
                s1_l     <= s0_l;
                for (int k = 0; k < LANES; k++) begin
                    s1_bn[k] <= bn_c[k];
                    s1_ma[k] <= s0_idx[k][LOGN-1:RADIX_LOG];
                end
            end
        end
    end

    // ---------------- inverse permutation ----------------
    // Later lanes overwrite earlier ones, so the highest lane wins a shared bank.
    // 16 lanes onto 16 banks: any bank left unhit implies a collision elsewhere.
    logic [MA_W-1:0]  perm_addr [LANES];
    bank_idx_t        perm_sel  [LANES];
    logic [LANES-1:0] bank_hit;
    logic             conflict_c;

    always_comb begin
        bank_hit = '0;
        for (int b = 0; b < LANES; b++) begin
            perm_addr[b] = '0;
            perm_sel[b]  = '0;
        end
        for (int m = 0; m < LANES; m++) begin
            perm_addr[s1_bn[m]] = s1_ma[m];
            perm_sel[s1_bn[m]]  = RADIX_LOG'(m);
            bank_hit[s1_bn[m]]  = 1'b1;
        end
        conflict_c = ~&bank_hit;
    end

    // ---------------- stage 2: outputs, counter, error flags ----------------
    // clr_pend remembers a done that was followed by idle cycles, so the next
    // valid group still starts the error flags afresh.
    logic clr_pend;
    logic first_grp;

    assign first_grp = map_done | clr_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            map_valid    <= 1'b0;
            map_done     <= 1'b0;
            map_l        <= '0;
            bank_addr    <= '0;
            lane_sel     <= '0;
            group_cnt    <= '0;
            conflict_err <= 1'b0;
            range_err    <= 1'b0;
            clr_pend     <= 1'b0;
        end else begin
            map_valid <= s1_valid;
            map_done  <= s1_valid & s1_done;
            group_cnt <= (map_done ? '0 : group_cnt) + MA_W'(s1_valid);
            if (s1_valid) begin
                for (int b = 0; b < LANES; b++) begin
                    bank_addr[b*MA_W +: MA_W]           <= perm_addr[b];
                    lane_sel[b*RADIX_LOG +: RADIX_LOG]  <= perm_sel[b];
                end
                map_l        <= s1_l;
                conflict_err <= conflict_c | (conflict_err & ~first_grp);
                range_err    <= s1_range   | (range_err & ~first_grp);
                clr_pend     <= 1'b0;
            end else if (map_done) begin
                clr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_bank_mapper.sv
// tb/tb_ntt_bank_mapper.sv - directed table-driven bench for ntt_bank_mapper
module tb_ntt_bank_mapper;

    localparam int DW   = 32;
    localparam int LOGN = 12;
    localparam int MA_W = LOGN - 4;
    localparam int NV   = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_en;
    logic [16*DW-1:0]   order_in;
    logic [DW-1:0]      in_l;
    logic               in_done;
    logic               map_valid;
    logic [16*MA_W-1:0] bank_addr;
    logic [63:0]        lane_sel;
    logic [DW-1:0]      map_l;
    logic               map_done;
    logic [MA_W-1:0]    group_cnt;
    logic               conflict_err;
    logic               range_err;

    ntt_bank_mapper #(.D_WIDTH(DW), .LOGN(LOGN)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_en        (in_en),
        .order_in     (order_in),
        .in_l         (in_l),
        .in_done      (in_done),
        .map_valid    (map_valid),
        .bank_addr    (bank_addr),
        .lane_sel     (lane_sel),
        .map_l        (map_l),
        .map_done     (map_done),
        .group_cnt    (group_cnt),
        .conflict_err (conflict_err),
        .range_err    (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16*DW-1:0]   order;
        logic               done;
        logic [16*MA_W-1:0] ea;
        logic [63:0]        es;
        logic               ec;
        logic               er;
        logic [MA_W-1:0]    ecnt;
    } vec_t;

    vec_t tv [NV];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_en    = 1'b0;
        order_in = '0;
        in_l     = '0;
        in_done  = 1'b0;

        // ---- vector table ----
        for (int i = 0; i < NV; i++) begin
            tv[i].order = '0;
            tv[i].ea    = '0;
            tv[i].es    = '0;
            tv[i].done  = 1'b0;
            tv[i].ec    = 1'b0;
            tv[i].er    = 1'b0;
            tv[i].ecnt  = '0;
        end
        for (int m = 0; m < 16; m++) begin
            // m*256: BN = m, MA = m*16
            tv[0].order[m*DW +: DW]           = 32'(m*256);
            tv[0].ea[m*MA_W +: MA_W]          = 8'(m*16);
            tv[0].es[m*4 +: 4]                = 4'(m);
            // m*256+1: BN = m+1, MA = m*16
            tv[1].order[m*DW +: DW]           = 32'(m*256 + 1);
            tv[1].ea[((m+1)%16)*MA_W +: MA_W] = 8'(m*16);
            tv[1].es[((m+1)%16)*4 +: 4]       = 4'(m);
            // m*16: BN = m, MA = m
            tv[2].order[m*DW +: DW]           = 32'(m*16);
            tv[2].ea[m*MA_W +: MA_W]          = 8'(m);
            tv[2].es[m*4 +: 4]                = 4'(m);
            // all lanes 5: everything lands on bank 5, MA = 0
            tv[3].order[m*DW +: DW]           = 32'd5;
        end
        tv[3].es[5*4 +: 4] = 4'd15;
        tv[4].order = tv[0].order; tv[4].ea = tv[0].ea; tv[4].es = tv[0].es;
        tv[5].order = tv[1].order; tv[5].ea = tv[1].ea; tv[5].es = tv[1].es;
        tv[6].order = tv[0].order; tv[6].ea = tv[0].ea; tv[6].es = tv[0].es;
        // lane 3 = 4096: low bits 0 -> bank 0 collides with lane 0; bank 3 empty
        tv[6].order[3*DW +: DW]  = 32'd4096;
        tv[6].ea[0 +: MA_W]      = 8'd0;
        tv[6].es[0 +: 4]         = 4'd3;
        tv[6].ea[3*MA_W +: MA_W] = 8'd0;
        tv[6].es[3*4 +: 4]       = 4'd0;

        tv[0].ecnt = 8'd1;
        tv[1].ecnt = 8'd2;
        tv[2].ecnt = 8'd3; tv[2].done = 1'b1;
        tv[3].ecnt = 8'd1; tv[3].ec = 1'b1;
        tv[4].ecnt = 8'd2; tv[4].ec = 1'b1; tv[4].done = 1'b1;
        tv[5].ecnt = 8'd1;
        tv[6].ecnt = 8'd2; tv[6].ec = 1'b1; tv[6].er = 1'b1;

        // ---- reset state ----
        tick(); tick(); tick();
        rst = 1'b0;
        chk("reset_valid", map_valid, 0);
        chk("reset_addr", bank_addr, 0);
        chk("reset_sel", lane_sel, 0);
        chk("reset_misc", {map_done, group_cnt, conflict_err, range_err, map_l}, 0);

        // ---- table vectors, one group at a time with idle gaps ----
        for (int i = 0; i < NV; i++) begin
            order_in = tv[i].order;
            in_l     = 32'(i + 3);
            in_done  = tv[i].done;
            in_en    = 1'b1;
            tick();
            in_en   = 1'b0;
            in_done = 1'b0;
            chk($sformatf("v%0d_lat1", i), map_valid, 0);
            tick();
            chk($sformatf("v%0d_lat2", i), map_valid, 0);
            tick();
            chk($sformatf("v%0d_valid", i), map_valid, 1);
            chk($sformatf("v%0d_addr", i), bank_addr, tv[i].ea);
            chk($sformatf("v%0d_sel", i), lane_sel, tv[i].es);
            chk($sformatf("v%0d_l", i), map_l, 32'(i + 3));
            chk($sformatf("v%0d_done", i), map_done, tv[i].done);
            chk($sformatf("v%0d_cnt", i), group_cnt, tv[i].ecnt);
            chk($sformatf("v%0d_conflict", i), conflict_err, tv[i].ec);
            chk($sformatf("v%0d_range", i), range_err, tv[i].er);
        end

        // ---- reset clears sticky flags and counter ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_flags", {conflict_err, range_err, group_cnt}, 0);

        // ---- 256 back-to-back groups, last one done ----
        for (int k = 0; k < 259; k++) begin
            if (k >= 3) begin
                chk($sformatf("stream_g%0d", k - 3),
                    {map_valid, map_done, group_cnt},
                    {1'b1, 1'((k - 3) == 255), 8'((k - 2) % 256)});
            end else begin
                chk($sformatf("stream_pre%0d", k), map_valid, 0);
            end
            if (k < 256) begin
                in_en    = 1'b1;
                order_in = tv[0].order;
                in_done  = (k == 255);
            end else begin
                in_en   = 1'b0;
                in_done = 1'b0;
            end
            tick();
        end
        chk("stream_after", {map_valid, map_done, group_cnt}, 0);
        chk("stream_clean", {conflict_err, range_err}, 0);

        // ---- populate outputs, then reset mid-stream ----
        order_in = tv[3].order;
        in_en    = 1'b1;
        tick();
        in_en = 1'b0;
        tick(); tick();
        chk("pre_rst_conflict", {map_valid, conflict_err, lane_sel[5*4 +: 4]}, {1'b1, 1'b1, 4'd15});

        order_in = tv[1].order;
        in_l     = 32'd77;
        in_en    = 1'b1;
        tick();
        in_en = 1'b0;
        tick();
        in_en = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        in_en = 1'b0;
        chk("midrst_valid", map_valid, 0);
        chk("midrst_addr", bank_addr, 0);
        chk("midrst_sel", lane_sel, 0);
        chk("midrst_misc", {map_done, group_cnt, conflict_err, range_err, map_l}, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("midrst_drain%0d", k), map_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
